// File: rtl/io_pipe_buf.sv
// io_pipe_buf: parametrised chain of elastic (skid-buffer) register slices.
// Each slice holds up to two words and presents a purely registered ready
// upstream, so no combinational ready path runs through the chain.
// STAGES=0 degenerates to a combinational pass-through.
//
// Ports:
//   clk        posedge clock
//   rst_n      asynchronous active-low reset
//   in_data    upstream word            in_valid / in_ready  upstream handshake
//   out_data   downstream word          out_valid / out_ready downstream handshake
//   level      number of words currently held (0..2*STAGES)
module io_pipe_buf #(
    parameter int unsigned          DATA_W    = 4,
    parameter int unsigned          STAGES    = 1,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    // Derived from STAGES; not meant to be overridden.
    parameter int unsigned          LVL_W     = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level
);

    if (STAGES == 0) begin : g_bypass
        // Pure wires: no storage, so reset and clock play no part.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign level     = '0;
    end else begin : g_pipe
        localparam int unsigned LVL_MAX = 2 * STAGES;

        // Inter-stage handshake: index k is the input side of stage k,
        // index STAGES is the block output.
        logic              v_chain   [STAGES+1];
        logic [DATA_W-1:0] d_chain   [STAGES+1];
        logic              rdy_chain [STAGES+1];
        logic              stg_mv    [STAGES];
        logic              stg_sv    [STAGES];
        logic              rst_done;
        logic              in_xfer;
        logic              out_xfer;
        logic [LVL_W-1:0]  occ;

        assign v_chain[0]        = in_valid;
        assign d_chain[0]        = in_data;
        assign rdy_chain[STAGES] = out_ready;
        assign in_ready          = rdy_chain[0];
        assign out_valid         = v_chain[STAGES];
        assign out_data          = d_chain[STAGES];

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic              m_v;
            logic              s_v;
            logic [DATA_W-1:0] m_d;
            logic [DATA_W-1:0] s_d;
            logic              push;
            logic              pop;

            assign push = v_chain[k] & rdy_chain[k];
            assign pop  = m_v & rdy_chain[k+1];

            // Head stage also refuses input until the first edge after reset release.
            if (k == 0) begin : g_head
                assign rdy_chain[k] = ~s_v & rst_done;
            end else begin : g_body
                assign rdy_chain[k] = ~s_v;
            end

            assign v_chain[k+1] = m_v;
            assign d_chain[k+1] = m_d;
            assign stg_mv[k]    = m_v;
            assign stg_sv[k]    = s_v;

            // EMPTY/HALF/FULL slice: main register drives out, skid catches
            // the word that arrives while downstream stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                    m_d <= RESET_VAL;
                    s_d <= RESET_VAL;
                end else if (pop) begin
                    if (s_v) begin
                        m_d <= s_d;
                        s_v <= 1'b0;
                    end else if (push) begin
                        m_d <= d_chain[k];
                    end else begin
                        m_v <= 1'b0;
                    end
                end else if (push) begin
                    if (!m_v) begin
                        m_v <= 1'b1;
                        m_d <= d_chain[k];
                    end else begin
                        s_v <= 1'b1;
                        s_d <= d_chain[k];
                    end
                end
            end
        end

        // Set on the first edge after reset release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rst_done <= 1'b0;
            end else begin
                rst_done <= 1'b1;
            end
        end

        assign in_xfer  = in_valid & in_ready;
        assign out_xfer = out_valid & out_ready;

        // Occupancy counter tracking block-level transfers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level <= '0;
            end else if (in_xfer && !out_xfer) begin
                level <= level + LVL_W'(1);
            end else if (out_xfer && !in_xfer) begin
                level <= level - LVL_W'(1);
            end
        end

        // Words actually held in the slices, used to cross-check level.
        always_comb begin
            occ = '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                occ = occ + LVL_W'(stg_mv[k]) + LVL_W'(stg_sv[k]);
            end
        end

        always @(posedge clk) begin
            if (rst_n) begin
                assert (level == occ);
                assert (32'(level) <= LVL_MAX);
                assert (!(in_xfer && !out_xfer && 32'(level) == LVL_MAX));
                assert (!(out_xfer && !in_xfer && level == '0));
            end
        end
    end

endmodule

// File: tb/tb_io_pipe_buf.sv
// Testbench for io_pipe_buf: four instances (STAGES 0/2/3/4), one exercised
// at a time; a queue-based FIFO model supplies expected data and occupancy.
module tb_io_pipe_buf;

    localparam int unsigned NI = 4;
    localparam int unsigned DW = 8;

    function automatic int unsigned st_of(input int g);
        case (g)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst_n;
    logic          out_ready;
    logic [DW-1:0] in_data   [NI];
    logic          in_valid  [NI];
    logic          in_ready  [NI];
    logic [DW-1:0] out_data  [NI];
    logic          out_valid [NI];
    logic [3:0]    level     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned S  = st_of(g);
        localparam int unsigned LW = (S == 0) ? 1 : $clog2(2 * S + 1);
        logic [LW-1:0] lvl;

        io_pipe_buf #(
            .DATA_W    (DW),
            .STAGES    (S),
            .RESET_VAL ((g == 1) ? 8'hA5 : 8'h00)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .level     (lvl)
        );
        assign level[g] = 4'(lvl);
    end

    int            ncmp    = 0;
    int            nfail   = 0;
    int            cur     = 1;
    int            cyc     = 0;
    bit            lat_chk = 1'b0;
    logic [DW-1:0] sb_d [$];
    int            sb_t [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the model on every output transfer of the active instance.
    always begin
        logic [DW-1:0] e;
        int            t;
        @(negedge clk);
        #2;
        if (rst_n && out_valid[cur] && out_ready) begin
            if (sb_d.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL unexpected_out: got data %0d with empty model (t=%0t)",
                         out_data[cur], $time);
            end else begin
                e = sb_d.pop_front();
                t = sb_t.pop_front();
                chk("out_data", int'(out_data[cur]), int'(e));
                if (lat_chk) chk("latency", cyc - t, int'(st_of(cur)) - 1);
            end
        end
    end

    // One clock: check occupancy, record any input transfer, return at posedge+1.
    task automatic step(output bit acc);
        @(negedge clk);
        chk("level", int'(level[cur]), sb_d.size());
        chk("level_max", int'(level[cur] <= 4'(2 * st_of(cur))), 1);
        acc = rst_n && in_valid[cur] && in_ready[cur];
        if (acc) begin
            sb_d.push_back(in_data[cur]);
            sb_t.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Offer base..base+n-1 back-to-back, holding each word until accepted.
    task automatic send_seq(input int base, input int n, input int budget);
        int i     = 0;
        int spent = 0;
        bit acc;
        in_valid[cur] = 1'b1;
        in_data[cur]  = DW'(base);
        while (i < n && spent < budget) begin
            step(acc);
            spent++;
            if (acc) begin
                i++;
                in_data[cur] = DW'(base + i);
            end
        end
        in_valid[cur] = 1'b0;
        chk("send_accepted", i, n);
    endtask

    task automatic drain(input int budget);
        int spent = 0;
        bit acc;
        in_valid[cur] = 1'b0;
        out_ready     = 1'b1;
        while (sb_d.size() != 0 && spent < budget) begin
            step(acc);
            spent++;
        end
        step(acc);
        chk("drained", sb_d.size(), 0);
    endtask

    task automatic chk_reset_state();
        for (int g = 1; g < NI; g++) begin
            chk("rst_out_valid", int'(out_valid[g]), 0);
            chk("rst_out_data", int'(out_data[g]), (g == 1) ? 'hA5 : 0);
            chk("rst_in_ready", int'(in_ready[g]), 0);
            chk("rst_level", int'(level[g]), 0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int g = 1; g < NI; g++) chk("in_ready_first_edge", int'(in_ready[g]), 0);
        @(posedge clk);
        #1;
        for (int g = 1; g < NI; g++) chk("in_ready_second_edge", int'(in_ready[g]), 1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        for (int g = 0; g < NI; g++) begin
            in_valid[g] = 1'b0;
            in_data[g]  = '0;
        end

        // Power-on reset state and release.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        release_reset();

        // Reset asserted mid-stream on the STAGES=2 instance.
        cur         = 1;
        out_ready   = 1'b1;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h30;
        for (int k = 0; k < 3; k++) begin
            step(acc);
            if (acc) in_data[1] = in_data[1] + 8'd1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        sb_d.delete();
        sb_t.delete();
        in_valid[1] = 1'b0;
        release_reset();

        // Streaming through STAGES=3 with fixed latency.
        cur     = 2;
        lat_chk = 1'b1;
        send_seq(0, 100, 300);
        drain(20);
        lat_chk = 1'b0;

        // Back-pressure fill on STAGES=2.
        cur         = 1;
        out_ready   = 1'b0;
        i           = 0;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h10;
        repeat (12) begin
            step(acc);
            if (acc) begin
                i++;
                in_data[1] = DW'(8'h10 + i);
            end
        end
        chk("fill_accepted", i, 4);
        chk("fill_in_ready", int'(in_ready[1]), 0);
        chk("fill_level", int'(level[1]), 4);
        out_ready = 1'b1;
        step(acc);
        chk("fill_ready_after_pop", int'(in_ready[1]), 0);
        step(acc);
        chk("fill_ready_recovered", int'(in_ready[1]), 1);
        for (int k = 0; k < 30 && i < 8; k++) begin
            step(acc);
            if (acc) begin
                i++;
                in_data[1] = DW'(8'h10 + i);
            end
        end
        in_valid[1] = 1'b0;
        chk("fill_total", i, 8);
        drain(20);

        // Random handshake on STAGES=4.
        cur = 3;
        i   = 0;
        for (int spent = 0; i < 10000 && spent < 60000; spent++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid[3]) begin
                in_valid[3] = 1'($urandom_range(0, 1));
                in_data[3]  = DW'($urandom);
            end
            step(acc);
            if (acc) begin
                i++;
                in_valid[3] = 1'b0;
            end
        end
        chk("rand_words", i, 10000);
        drain(40);

        // Combinational pass-through (STAGES=0).
        cur = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid[0] = k[0];
            out_ready   = k[1];
            in_data[0]  = k[2] ? 8'h0C : 8'h03;
            #1;
            chk("pt_data", int'(out_data[0]), k[2] ? 12 : 3);
            chk("pt_valid", int'(out_valid[0]), int'(k[0]));
            chk("pt_ready", int'(in_ready[0]), int'(k[1]));
            chk("pt_level", int'(level[0]), 0);
            step(acc);
        end
        drain(4);

        // Reset while full: stale words must never reappear.
        cur       = 1;
        out_ready = 1'b0;
        send_seq('hE0, 4, 20);
        chk("full_level", int'(level[1]), 4);
        chk("full_in_ready", int'(in_ready[1]), 0);
        #2;
        rst_n = 1'b0;
        sb_d.delete();
        sb_t.delete();
        #10;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
            step(acc);
            chk("post_rst_valid", int'(out_valid[1]), 0);
        end
        send_seq('h50, 4, 20);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
